i2c_txn_arbiter: RTL and testbench
==================================

Name: i2c_txn_arbiter

Overview:
- Sequencer and round-robin arbiter that shares one byte-level I2C write master between NREQ requesters (LCD backpack at 0x27, expander, etc.).
- Each requester submits a complete write transaction: 7-bit address plus 1..4 data bytes.
- The block owns the transaction: it emits the START pulse, feeds the address and data bytes, checks ACK per byte, issues STOP, enforces a timeout and reports per-requester status.

Parameters:
- NREQ, 2, number of requesters (2..4).
- TIMEOUT, 4095, max cycles to wait for any single master event before aborting.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-low
- req_valid  in  NREQ  requester i has a pending transaction (level, held until grant)
- req_addr  in  7*NREQ  7-bit slave address, slice i
- req_len  in  2*NREQ  data byte count minus 1, slice i
- req_data  in  32*NREQ  data bytes, byte k = bits [8k+7:8k] of slice i
- grant  out  NREQ  one-hot, high for the whole transaction of the owner
- done  out  NREQ  1-cycle pulse, transaction finished, all bytes ACKed
- err  out  NREQ  1-cycle pulse, transaction aborted (NACK or timeout)
- m_start  out  1  1-cycle pulse, master issues START and shifts m_byte
- m_byte  out  8  byte being sent; stable from m_start/advance until the next m_byte_done
- m_byte_done  in  1  1-cycle pulse from master after the ACK slot of a byte
- m_ack  in  1  1 = slave ACKed; valid only with m_byte_done
- m_stop  out  1  1-cycle pulse, master issues STOP
- m_busy  in  1  master busy (START..STOP complete)

Behaviour:
- Reset (rst=0 at posedge):
  - state=IDLE, grant=0, done=0, err=0, m_start=0, m_stop=0, m_byte=0.
  - rr pointer = NREQ-1, so requester 0 has first priority.
  - Reset mid-transaction drops everything without issuing STOP; the master is reset by the same rst.
- States: IDLE, GRANT, START, BYTE, STOP, WAIT_IDLE.
- IDLE:
  - If any req_valid and m_busy=0, select the first valid index searching from ptr+1 modulo NREQ.
  - Latch that index's addr, len and data; set grant one-hot; ptr <= index; go GRANT.
  - grant rises 1 cycle after the selecting req_valid edge.
- GRANT: m_byte <= {addr,1'b0}, byte counter k <= 0, go START.
- START: m_start pulses for one cycle, timeout counter cleared, go BYTE.
- BYTE, waiting for m_byte_done:
  - Timeout counter increments every cycle.
  - If counter reaches TIMEOUT with no m_byte_done: set the abort flag, go STOP.
  - m_byte_done with m_ack=0: abort flag set, go STOP.
  - m_byte_done with m_ack=1 and bytes remaining: m_byte <= next data byte on the following cycle, counter cleared, stay in BYTE.
  - m_byte_done with m_ack=1 after data byte req_len (last byte): go STOP.
  - Total bytes per transaction = req_len + 2.
- STOP: m_stop pulses for one cycle, go WAIT_IDLE.
- WAIT_IDLE:
  - Wait for m_busy=0, with its own timeout counter; on timeout, force completion with the abort flag set.
  - Then, in the same cycle: grant <= 0; pulse done[owner] if no abort, else err[owner]; go IDLE.
  - A new grant is possible at the earliest 1 cycle later.
- Latched data: req_* are sampled only at grant. A requester may change its inputs or drop req_valid after grant with no effect. A requester dropping req_valid before grant is simply not selected.
- Simultaneous requests: strict round-robin, so no requester gets two consecutive grants while another is valid.
- Ignored inputs: m_byte_done outside BYTE is ignored; m_ack is ignored without m_byte_done.
- Exclusivity: done and err are never both high. At most one grant bit is high at any time.

Test Plan:
- Single write: req0 addr=0x27, len=2, data=0x00_02_81_00 (bytes 0x00,0x81,0x02), master model ACKs all.
  - m_byte sequence 0x4E,0x00,0x81,0x02; one m_start, one m_stop; done[0] pulses once; err=0.
- Contention: req0 and req1 valid in the same cycle after reset.
  - req0 granted first, then req1; re-assert both and req1 is granted... no: re-assert both and req0 is granted next (ptr rotated); grant never overlaps.
- NACK on address: model returns m_ack=0 for byte 0x4E.
  - m_stop follows within 2 cycles; no data byte driven; err[owner] pulses; done stays 0.
- Timeout: model never pulses m_byte_done.
  - m_stop pulses TIMEOUT+1 cycles after m_start (±1); err pulses; next request serviced normally.
- Reset mid-transaction: assert rst=0 during the second data byte.
  - Next cycle grant=0, m_start=0, m_stop=0, state=IDLE; a subsequent req1 transaction completes with done[1].
- Input change after grant: change req_data of the owner one cycle after grant.
  - Bytes sent equal the originally latched values.

Source files
------------

// File: rtl/i2c_txn_arbiter_if.sv
// -----------------------------------------------------------------------------
// i2c_txn_arbiter_if
//
// Groups every non-clock signal of the I2C transaction arbiter into one bundle.
// Two groups of signals travel through it:
//   - the requester side: NREQ packed request slots plus grant/done/err;
//   - the byte-master side: START/STOP pulses, the byte being shifted, and the
//     per-byte completion/ACK handshake coming back from the shared master.
//
// Modports:
//   master - the arbiter's view: it consumes the requests and the master's
//            replies, and drives grants, status pulses and master commands.
//   slave  - the environment's view (requesters plus the byte-level I2C
//            write master): the exact mirror of 'master'.
//
// Signals:
//   req_valid   [NREQ]     requester i has a pending transaction (level)
//   req_addr    [7*NREQ]   7-bit slave address, slice i
//   req_len     [2*NREQ]   data byte count minus 1, slice i
//   req_data    [32*NREQ]  data bytes, byte k = bits [8k+7:8k] of slice i
//   grant       [NREQ]     one-hot owner of the current transaction
//   done        [NREQ]     1-cycle pulse, transaction completed with all ACKs
//   err         [NREQ]     1-cycle pulse, transaction aborted
//   m_start                1-cycle START command to the byte master
//   m_byte      [8]        byte currently being shifted out
//   m_byte_done            1-cycle pulse after the ACK slot of a byte
//   m_ack                  slave ACKed; qualified by m_byte_done
//   m_stop                 1-cycle STOP command to the byte master
//   m_busy                 byte master busy from START until STOP completes
// -----------------------------------------------------------------------------
interface i2c_txn_arbiter_if #(
  parameter int NREQ = 2
);
  // Requester side
  logic [NREQ-1:0]    req_valid;
  logic [7*NREQ-1:0]  req_addr;
  logic [2*NREQ-1:0]  req_len;
  logic [32*NREQ-1:0] req_data;
  logic [NREQ-1:0]    grant;
  logic [NREQ-1:0]    done;
  logic [NREQ-1:0]    err;

  // Byte-master side
  logic               m_start;
  logic [7:0]         m_byte;
  logic               m_byte_done;
  logic               m_ack;
  logic               m_stop;
  logic               m_busy;

  modport master (
    input  req_valid, req_addr, req_len, req_data,
    input  m_byte_done, m_ack, m_busy,
    output grant, done, err,
    output m_start, m_byte, m_stop
  );

  modport slave (
    output req_valid, req_addr, req_len, req_data,
    output m_byte_done, m_ack, m_busy,
    input  grant, done, err,
    input  m_start, m_byte, m_stop
  );
endinterface

// File: rtl/i2c_txn_arbiter.sv
// -----------------------------------------------------------------------------
// i2c_txn_arbiter
//
// Shares one byte-level I2C write master between NREQ requesters. Each
// requester posts a complete write (7-bit address plus 1..4 data bytes); the
// arbiter picks one round-robin, latches its payload, then sequences the
// master: START, address byte, data bytes with an ACK check after each, STOP,
// and finally waits for the master to go idle before reporting done or err
// to the owner.
//
// Parameters:
//   NREQ     number of requesters (2..4)
//   TIMEOUT  maximum cycles to wait for any single master event
//
// Ports:
//   clk  system clock
//   rst  synchronous reset, active low
//   bus  i2c_txn_arbiter_if.master (requests, status and byte-master link)
//
// Timing summary:
//   grant rises one cycle after the selecting req_valid is sampled in IDLE;
//   m_start pulses two cycles after that; each ACKed byte loads the next
//   data byte on the following cycle; done/err pulse in the same cycle grant
//   falls.
// -----------------------------------------------------------------------------
module i2c_txn_arbiter #(
  parameter int NREQ    = 2,
  parameter int TIMEOUT = 4095
) (
  input  logic              clk,
  input  logic              rst,
  i2c_txn_arbiter_if.master bus
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_GRANT,
    S_START,
    S_BYTE,
    S_STOP,
    S_WAIT_IDLE
  } state_e;

  state_e state_q, state_d;

  // Arbitration and ownership
  logic [PW-1:0]   ptr_q;        // last granted index
  logic [NREQ-1:0] grant_q;
  logic [NREQ-1:0] done_q;
  logic [NREQ-1:0] err_q;

  // Latched transaction payload
  logic [6:0]      addr_q;
  logic [1:0]      len_q;
  logic [3:0][7:0] data_q;

  // Sequencing
  logic [7:0]      byte_q;       // drives m_byte
  logic [2:0]      idx_q;        // 0 = address byte, n = data byte n-1
  logic [CW-1:0]   tmo_q;
  logic            abort_q;

  // Round-robin selection results
  logic            sel_found;
  logic [NREQ-1:0] sel_oh;
  logic [PW-1:0]   sel_idx;
  logic [6:0]      sel_addr;
  logic [1:0]      sel_len;
  logic [3:0][7:0] sel_data;

  logic            tmo_hit;
  logic            last_byte;
  logic            take_grant;

  // ---------------------------------------------------------------------------
  // Round-robin pick: first valid index strictly after ptr_q, wrapping around.
  // Pass 0 scans indices above ptr_q, pass 1 scans the rest from 0 upwards,
  // which is the modulo-NREQ search order without a divider.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of a combinational block gets a default before any
    // branch; a path that leaves a variable unassigned infers a latch.
    sel_found = 1'b0;
    sel_oh    = '0;
    sel_idx   = '0;
    sel_addr  = '0;
    sel_len   = '0;
    sel_data  = '0;
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!sel_found && bus.req_valid[i] &&
            ((pass == 0) == (i > int'(ptr_q)))) begin
          sel_found = 1'b1;
          sel_oh[i] = 1'b1;
          sel_idx   = PW'(i);
          sel_addr  = bus.req_addr[7*i +: 7];
          sel_len   = bus.req_len[2*i +: 2];
          sel_data  = bus.req_data[32*i +: 32];
        end
      end
    end
  end

  // The counter is cleared on entry to each wait, so reaching TIMEOUT-1 here
  // means this is the TIMEOUT-th cycle spent waiting.
  assign tmo_hit    = (tmo_q == CW'(TIMEOUT - 1));
  assign last_byte  = (idx_q == ({1'b0, len_q} + 3'd1));
  assign take_grant = sel_found && !bus.m_busy;

  // ---------------------------------------------------------------------------
  // FSM process 1: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM process 2: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (take_grant) state_d = S_GRANT;
      end
      S_GRANT: begin
        state_d = S_START;
      end
      S_START: begin
        state_d = S_BYTE;
      end
      S_BYTE: begin
        // A byte completion takes priority over a coincident timeout.
        if (bus.m_byte_done) begin
          if (!bus.m_ack || last_byte) state_d = S_STOP;
        end else if (tmo_hit) begin
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        state_d = S_WAIT_IDLE;
      end
      S_WAIT_IDLE: begin
        if (!bus.m_busy || tmo_hit) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM process 3: state-decoded command pulses
  // ---------------------------------------------------------------------------
  always_comb begin
    bus.m_start = 1'b0;
    bus.m_stop  = 1'b0;
    case (state_q)
      S_START: bus.m_start = 1'b1;
      S_STOP:  bus.m_stop  = 1'b1;
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Control datapath: grant, pointer, byte sequencing, timeout, status pulses
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr_q   <= PW'(NREQ - 1);    // requester 0 wins the first arbitration
      grant_q <= '0;
      done_q  <= '0;
      err_q   <= '0;
      byte_q  <= '0;
      idx_q   <= '0;
      tmo_q   <= '0;
      abort_q <= 1'b0;
    end else begin
      done_q <= '0;
      err_q  <= '0;
      case (state_q)
        S_IDLE: begin
          if (take_grant) begin
            grant_q <= sel_oh;
            ptr_q   <= sel_idx;
          end
        end
        S_GRANT: begin
          byte_q  <= {addr_q, 1'b0};   // write direction
          idx_q   <= '0;
          abort_q <= 1'b0;
        end
        S_START: begin
          tmo_q <= '0;
        end
        S_BYTE: begin
          if (bus.m_byte_done) begin
            if (!bus.m_ack) begin
              abort_q <= 1'b1;
            end else if (!last_byte) begin
              // idx_q is never above len_q here, so idx_q[1:0] is the index
              // of the next data byte.
              byte_q <= data_q[idx_q[1:0]];
              idx_q  <= idx_q + 3'd1;
              tmo_q  <= '0;
            end
          end else begin
            tmo_q <= tmo_q + 1'b1;
            if (tmo_hit) abort_q <= 1'b1;
          end
        end
        S_STOP: begin
          tmo_q <= '0;
        end
        S_WAIT_IDLE: begin
          if (!bus.m_busy || tmo_hit) begin
            grant_q <= '0;
            // Still busy here means the idle wait timed out.
            if (abort_q || bus.m_busy) err_q  <= grant_q;
            else                       done_q <= grant_q;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Payload latch, captured only at grant time
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: payload registers carry no reset; they are always written at grant
    // before anything reads them, and leaving them out keeps rst off their
    // enable path.
    if (state_q == S_IDLE && take_grant) begin
      addr_q <= sel_addr;
      len_q  <= sel_len;
      data_q <= sel_data;
    end
  end

  assign bus.grant  = grant_q;
  assign bus.done   = done_q;
  assign bus.err    = err_q;
  assign bus.m_byte = byte_q;

  // ---------------------------------------------------------------------------
  // Structural invariants
  // ---------------------------------------------------------------------------
  a_grant_onehot: assert property (@(posedge clk) disable iff (!rst)
    $onehot0(grant_q));
  a_done_err_excl: assert property (@(posedge clk) disable iff (!rst)
    !(|done_q && |err_q));

endmodule

// File: tb/tb_i2c_txn_arbiter.sv
// -----------------------------------------------------------------------------
// tb_i2c_txn_arbiter
//
// Directed bench for i2c_txn_arbiter with NREQ=2 and a short TIMEOUT. A small
// byte-master model answers START/byte/STOP in one of three modes (ACK all,
// NACK the address byte, never answer) and logs every byte it is asked to
// shift. Expected byte streams, grant order and pulse counts are written by
// hand in each test.
// -----------------------------------------------------------------------------
module tb_i2c_txn_arbiter;

  localparam int NREQ     = 2;
  localparam int TMO      = 60;
  localparam int BYTE_DLY = 3;

  typedef enum int { M_ACK, M_NACK_ADDR, M_SILENT } mode_e;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  i2c_txn_arbiter_if #(.NREQ(NREQ)) bus ();

  i2c_txn_arbiter #(
    .NREQ    (NREQ),
    .TIMEOUT (TMO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int         total = 0;
  int         bad   = 0;
  int         cyc   = 0;
  mode_e      mode  = M_ACK;

  logic [7:0] blog[$];
  int         n_start, n_stop, n_done0, n_done1, n_err, n_viol;
  int         start_cyc, stop_cyc, done_cyc;
  int         pend_cnt, stop_cnt;
  bit         pend, prev_done;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Byte-master model and bus monitors
  always @(negedge clk) begin
    if (!$onehot0(bus.grant)) n_viol++;
    if (|bus.done && |bus.err) n_viol++;
    if (bus.done[0]) n_done0++;
    if (bus.done[1]) n_done1++;
    if (|bus.err)    n_err++;

    if (!rst) begin
      bus.m_busy      = 1'b0;
      bus.m_byte_done = 1'b0;
      bus.m_ack       = 1'b0;
      pend            = 1'b0;
      prev_done       = 1'b0;
      pend_cnt        = 0;
      stop_cnt        = 0;
    end else begin
      bus.m_byte_done = 1'b0;
      bus.m_ack       = 1'b0;
      if (bus.m_start) begin
        n_start++;
        start_cyc  = cyc;
        bus.m_busy = 1'b1;
        blog.push_back(bus.m_byte);
        pend       = 1'b1;
        pend_cnt   = BYTE_DLY;
      end else if (prev_done && !bus.m_stop) begin
        blog.push_back(bus.m_byte);
        pend     = 1'b1;
        pend_cnt = BYTE_DLY;
      end
      prev_done = 1'b0;
      if (bus.m_stop) begin
        n_stop++;
        stop_cyc = cyc;
        pend     = 1'b0;
        stop_cnt = 2;
      end else if (pend && mode != M_SILENT) begin
        if (pend_cnt == 0) begin
          bus.m_byte_done = 1'b1;
          bus.m_ack       = !(mode == M_NACK_ADDR && blog.size() == 1);
          pend            = 1'b0;
          prev_done       = 1'b1;
          done_cyc        = cyc;
        end else begin
          pend_cnt--;
        end
      end
      if (stop_cnt != 0) begin
        stop_cnt--;
        if (stop_cnt == 0) bus.m_busy = 1'b0;
      end
    end
  end

  task automatic clear_stats();
    blog.delete();
    n_start = 0; n_stop = 0; n_done0 = 0; n_done1 = 0; n_err = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    bus.req_valid = '0;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic start_req(input int idx, input logic [6:0] addr,
                           input logic [1:0] len, input logic [31:0] data);
    bus.req_addr[7*idx +: 7]   = addr;
    bus.req_len[2*idx +: 2]    = len;
    bus.req_data[32*idx +: 32] = data;
    bus.req_valid[idx]         = 1'b1;
  endtask

  task automatic wait_grant(input string tag, input int idx);
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (bus.grant != '0) break;
    end
    check(tag, 32'(bus.grant), 32'(1 << idx));
    bus.req_valid[idx] = 1'b0;
  endtask

  task automatic wait_end(input string tag, input logic [1:0] exp_done,
                          input logic [1:0] exp_err, input int budget);
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      if (|bus.done || |bus.err) break;
    end
    check({tag, "_done"}, 32'(bus.done), 32'(exp_done));
    check({tag, "_err"},  32'(bus.err),  32'(exp_err));
  endtask

  logic [7:0] exp1[4] = '{8'h4E, 8'h00, 8'h81, 8'h02};
  logic [7:0] exp6[5] = '{8'h4E, 8'hAA, 8'hBB, 8'hCC, 8'hDD};

  initial begin
    int d;
    bus.req_valid = '0;
    bus.req_addr  = '0;
    bus.req_len   = '0;
    bus.req_data  = '0;
    n_viol        = 0;
    clear_stats();

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_grant",   32'(bus.grant),   32'h0);
    check("rst_done",    32'(bus.done),    32'h0);
    check("rst_err",     32'(bus.err),     32'h0);
    check("rst_m_start", 32'(bus.m_start), 32'h0);
    check("rst_m_stop",  32'(bus.m_stop),  32'h0);
    check("rst_m_byte",  32'(bus.m_byte),  32'h0);
    rst = 1'b1;

    // Single write: 0x27, three data bytes 0x00,0x81,0x02
    mode = M_ACK;
    start_req(0, 7'h27, 2'd2, 32'h0002_8100);
    wait_grant("t1_grant", 0);
    wait_end("t1", 2'b01, 2'b00, 200);
    repeat (4) @(negedge clk);
    check("t1_nbytes", 32'(blog.size()), 32'd4);
    for (int i = 0; i < 4; i++) check($sformatf("t1_byte%0d", i),
                                      32'(blog[i]), 32'(exp1[i]));
    check("t1_nstart", 32'(n_start), 32'd1);
    check("t1_nstop",  32'(n_stop),  32'd1);
    check("t1_ndone0", 32'(n_done0), 32'd1);
    check("t1_nerr",   32'(n_err),   32'd0);

    // Contention straight after reset: 0 then 1, then 0 again on re-request
    do_reset();
    clear_stats();
    start_req(0, 7'h20, 2'd0, 32'h0000_00A0);
    start_req(1, 7'h21, 2'd0, 32'h0000_00A1);
    wait_grant("t2_first", 0);
    wait_end("t2a", 2'b01, 2'b00, 200);
    wait_grant("t2_second", 1);
    wait_end("t2b", 2'b10, 2'b00, 200);
    @(negedge clk);
    start_req(0, 7'h20, 2'd0, 32'h0000_00B0);
    start_req(1, 7'h21, 2'd0, 32'h0000_00B1);
    wait_grant("t2_third", 0);
    wait_end("t2c", 2'b01, 2'b00, 200);
    wait_grant("t2_fourth", 1);
    wait_end("t2d", 2'b10, 2'b00, 200);
    repeat (4) @(negedge clk);

    // NACK on the address byte
    clear_stats();
    mode = M_NACK_ADDR;
    start_req(0, 7'h27, 2'd1, 32'h0000_1234);
    wait_grant("t3_grant", 0);
    wait_end("t3", 2'b00, 2'b01, 200);
    check("t3_nbytes", 32'(blog.size()), 32'd1);
    check("t3_byte0",  32'(blog[0]), 32'h4E);
    d = stop_cyc - done_cyc;
    check("t3_stop_lat", 32'(d >= 1 && d <= 2), 32'd1);
    check("t3_ndone", 32'(n_done0 + n_done1), 32'd0);
    repeat (4) @(negedge clk);

    // Timeout: master never answers
    clear_stats();
    mode = M_SILENT;
    start_req(1, 7'h33, 2'd0, 32'h0000_0055);
    wait_grant("t4_grant", 1);
    wait_end("t4", 2'b00, 2'b10, TMO + 50);
    d = stop_cyc - start_cyc;
    check("t4_tmo_lat", 32'(d >= TMO && d <= TMO + 2), 32'd1);
    repeat (4) @(negedge clk);
    clear_stats();
    mode = M_ACK;
    start_req(0, 7'h27, 2'd0, 32'h0000_003C);
    wait_grant("t4_next_grant", 0);
    wait_end("t4_next", 2'b01, 2'b00, 200);
    check("t4_next_nbytes", 32'(blog.size()), 32'd2);
    repeat (4) @(negedge clk);

    // Reset during the second data byte
    clear_stats();
    start_req(0, 7'h27, 2'd2, 32'h0003_0201);
    wait_grant("t5_grant", 0);
    for (int n = 0; n < 100; n++) begin
      if (blog.size() >= 3) break;
      @(negedge clk);
    end
    check("t5_reached_byte2", 32'(blog.size()), 32'd3);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("t5_grant",   32'(bus.grant),   32'h0);
    check("t5_m_start", 32'(bus.m_start), 32'h0);
    check("t5_m_stop",  32'(bus.m_stop),  32'h0);
    check("t5_m_byte",  32'(bus.m_byte),  32'h0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    check("t5_nstop", 32'(n_stop), 32'd0);
    start_req(1, 7'h40, 2'd0, 32'h0000_0077);
    wait_grant("t5_after_grant", 1);
    wait_end("t5_after", 2'b10, 2'b00, 200);
    repeat (4) @(negedge clk);

    // Owner's inputs change one cycle after grant
    clear_stats();
    start_req(0, 7'h27, 2'd3, 32'hDDCC_BBAA);
    wait_grant("t6_grant", 0);
    @(negedge clk);
    bus.req_data[31:0] = 32'h1122_3344;
    bus.req_addr[6:0]  = 7'h55;
    bus.req_len[1:0]   = 2'd0;
    wait_end("t6", 2'b01, 2'b00, 300);
    check("t6_nbytes", 32'(blog.size()), 32'd5);
    for (int i = 0; i < 5; i++) check($sformatf("t6_byte%0d", i),
                                      32'(blog[i]), 32'(exp6[i]));
    repeat (4) @(negedge clk);

    check("invariant_violations", 32'(n_viol), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
